// File: rtl/ffjk_bank.sv
// Bank of WIDTH JK flip-flops with JK, parallel-load, shift and up/down count modes.
// Define FFJK_BANK_SAT_EN for a saturating counter; otherwise the counter wraps.
module ffjk_bank #(
    parameter int              WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN,
    output logic [WIDTH-1:0] Q,
    output logic             CHG,
    output logic             TC
);

    localparam logic [1:0]       MODE_JK    = 2'b00;
    localparam logic [1:0]       MODE_LOAD  = 2'b01;
    localparam logic [1:0]       MODE_SHIFT = 2'b10;
    localparam logic [1:0]       MODE_COUNT = 2'b11;
    localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZEROS  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             chg_q, chg_d;
    logic             tc_q, tc_d;

    // Next-state selection for the bank and its flags (reset is applied in the register)
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (ENABLE) begin
            case (MODE)
                MODE_JK:    q_d = (J & ~q_q) | (~K & q_q);
                MODE_LOAD:  q_d = D;
                MODE_SHIFT: q_d = {q_q[WIDTH-2:0], SIN};
                MODE_COUNT: begin
`ifdef FFJK_BANK_SAT_EN
                    // At the limit the count holds and reports the attempt via TC
                    if (!SIN) begin
                        if (q_q == ALL_ONES) begin
                            q_d  = q_q;
                            tc_d = 1'b1;
                        end else begin
                            q_d  = q_q + ONE;
                        end
                    end else begin
                        if (q_q == ALL_ZEROS) begin
                            q_d  = q_q;
                            tc_d = 1'b1;
                        end else begin
                            q_d  = q_q - ONE;
                        end
                    end
`else
                    if (!SIN) begin
                        q_d  = q_q + ONE;
                        tc_d = (q_q == ALL_ONES);
                    end else begin
                        q_d  = q_q - ONE;
                        tc_d = (q_q == ALL_ZEROS);
                    end
`endif
                end
                default:    q_d = q_q;
            endcase
        end else begin
            q_d  = q_q;
            tc_d = 1'b0;
        end
        chg_d = ENABLE && (q_d != q_q);
    end

    // State and flag registers with synchronous reset taking priority
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q   <= RST_VAL;
            chg_q <= 1'b0;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            tc_q  <= tc_d;
        end
    end

    assign Q   = q_q;
    assign CHG = chg_q;
    assign TC  = tc_q;

endmodule

// File: tb/tb_ffjk_bank.sv
// Self-checking bench for ffjk_bank (WIDTH=4, RST_VAL=0): arithmetic reference model
// checked every cycle, plus hand-computed expectations from the directed scenarios.
module tb_ffjk_bank;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ENABLE = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [3:0] J = 4'b0000, K = 4'b0000, D = 4'b0000;
    logic       SIN = 1'b0;
    logic [3:0] Q;
    logic       CHG, TC;

    int vectors = 0;
    int errors  = 0;

    int mq = 0;
    bit mchg = 1'b0, mtc = 1'b0, mvalid = 1'b0;

    ffjk_bank #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .MODE(MODE),
        .J(J), .K(K), .D(D), .SIN(SIN),
        .Q(Q), .CHG(CHG), .TC(TC)
    );

    always #5 CLK = ~CLK;

    // Reference model: operations computed on an integer, bit-by-bit for JK
    always @(posedge CLK) begin
        int nq;
        nq = mq;
        if (RST) begin
            mq = 0; mchg = 1'b0; mtc = 1'b0; mvalid = 1'b1;
        end else if (!ENABLE) begin
            mchg = 1'b0; mtc = 1'b0;
        end else begin
            mtc = 1'b0;
            if (MODE == 2'd0) begin
                nq = 0;
                for (int i = 0; i < 4; i++) begin
                    int qb;
                    int nb;
                    qb = (mq >> i) & 1;
                    if (J[i] && K[i])      nb = 1 - qb;
                    else if (J[i])         nb = 1;
                    else if (K[i])         nb = 0;
                    else                   nb = qb;
                    nq = nq + (nb << i);
                end
            end else if (MODE == 2'd1) begin
                nq = int'(D);
            end else if (MODE == 2'd2) begin
                nq = (mq * 2 + int'(SIN)) % 16;
            end else begin
`ifdef FFJK_BANK_SAT_EN
                if (!SIN && mq == 15)     begin nq = 15; mtc = 1'b1; end
                else if (SIN && mq == 0)  begin nq = 0;  mtc = 1'b1; end
                else if (!SIN)            nq = mq + 1;
                else                      nq = mq - 1;
`else
                if (!SIN) begin nq = (mq + 1) % 16;  mtc = (mq == 15); end
                else      begin nq = (mq + 15) % 16; mtc = (mq == 0);  end
`endif
            end
            mchg = (nq != mq);
            mq = nq;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (mvalid) begin
            vectors++;
            if (Q !== 4'(mq) || CHG !== mchg || TC !== mtc) begin
                errors++;
                $display("FAIL model: Q=%b CHG=%b TC=%b required Q=%b CHG=%b TC=%b",
                         Q, CHG, TC, 4'(mq), mchg, mtc);
            end
        end
    end

    task automatic cyc(input logic rst, input logic en, input logic [1:0] md,
                       input logic [3:0] j, input logic [3:0] k, input logic [3:0] d,
                       input logic s);
        @(negedge CLK);
        #2;
        RST = rst; ENABLE = en; MODE = md; J = j; K = k; D = d; SIN = s;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] q, input logic c, input logic t);
        vectors++;
        if (Q !== q || CHG !== c || TC !== t) begin
            errors++;
            $display("FAIL %s: Q=%b CHG=%b TC=%b required Q=%b CHG=%b TC=%b",
                     name, Q, CHG, TC, q, c, t);
        end
    endtask

    initial begin
        // Reset state
        cyc(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("reset", 4'b0000, 1'b0, 1'b0);

        // Reset priority over an enabled load
        cyc(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 4'b1010, 1'b0);
        chk("load1010", 4'b1010, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 2'b01, 4'b0000, 4'b0000, 4'b1111, 1'b0);
        chk("rst_prio", 4'b0000, 1'b0, 1'b0);

        // JK: hold, clear, set, toggle across the four bits
        cyc(1'b0, 1'b1, 2'b00, 4'b1100, 4'b1010, 4'b0000, 1'b0);
        chk("jk1", 4'b1100, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 4'b1100, 4'b1010, 4'b0000, 1'b0);
        chk("jk2", 4'b0100, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        chk("jk_disabled", 4'b0100, 1'b0, 1'b0);

        // Shift
        cyc(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        chk("load0001", 4'b0001, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("shift1", 4'b0011, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("shift2", 4'b0111, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("shift3", 4'b1111, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("shift4", 4'b1110, 1'b1, 1'b0);

        // Count up through the top
        cyc(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 4'b1110, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 4'b1111, 4'b1111, 4'b0101, 1'b0);
        chk("up1", 4'b1111, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b0);
`ifdef FFJK_BANK_SAT_EN
        chk("up_sat", 4'b1111, 1'b0, 1'b1);
`else
        chk("up_wrap", 4'b0000, 1'b1, 1'b1);
`endif

        // Count down through zero
        cyc(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("down1", 4'b0000, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b1);
`ifdef FFJK_BANK_SAT_EN
        chk("down_sat", 4'b0000, 1'b0, 1'b1);
`else
        chk("down_wrap", 4'b1111, 1'b1, 1'b1);
`endif

        // Enable gating and mid-count reset
        cyc(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0011, 1'b0);
        cyc(1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("hold1", 4'b0011, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("hold2", 4'b0011, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("recount", 4'b0100, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("mid_rst", 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b1);
`ifdef FFJK_BANK_SAT_EN
        chk("after_rst", 4'b0000, 1'b0, 1'b1);
`else
        chk("after_rst", 4'b1111, 1'b1, 1'b1);
`endif

        // Mixed pseudo-random operations, checked by the model only
        for (int n = 0; n < 60; n++) begin
            cyc((($urandom % 16) == 0), (($urandom % 4) != 0), 2'($urandom),
                4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
